uart_rx: RTL
============

# uart_rx

Serial UART receiver: the counterpart of the UART transmitter, sitting directly downstream of the serial line. It oversamples the line at 16 ticks per bit, recovers start, data, optional parity and stop bits, and presents the assembled word with a one-cycle done strobe plus parity and framing error flags. It is driven by the same tick source and uses the same frame parameters as the transmitter, so a tx→rx loopback is bit-exact.

## Interface
- NB_DATA, 8, width of o_data
- N_DATA, 8, data bits per frame (≤ NB_DATA); unused upper o_data bits read 0
- LOG2_N_DATA, 4, width of data-bit counter
- PARITY_CHECK, 1, 1 = parity bit present after data, 0 = absent
- EVEN_ODD_PARITY, 1, 1 = even parity (data ones + parity bit even), 0 = odd
- M_STOP, 1, stop bits per frame
- LOG2_M_STOP, 1, width of stop-bit counter

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_data  in  1  serial line, idle high
- i_valid  in  1  oversampling tick, one-clock pulse, 16 per bit period
- o_data  out  NB_DATA  last received word, LSB received first
- o_rx_done  out  1  one-cycle pulse when a frame completes
- o_parity_error  out  1  parity mismatch on last frame (0 if PARITY_CHECK=0)
- o_frame_error  out  1  a stop bit sampled low on last frame

## Operation
- States: IDLE, START, DATA, PARITY, STOP. 4-bit tick counter; bit counter LOG2_N_DATA wide; stop counter LOG2_M_STOP wide.
- All counters and state advance only on cycles with i_valid=1; without ticks the block holds.
- IDLE: on tick with sampled line = 0 → START, tick counter cleared.
- START: at tick count 7 (mid-bit): line 0 → DATA, counter cleared; line 1 → IDLE (glitch rejected, no done).
- DATA: every 16th tick sample line, shift in LSB-first; after N_DATA samples → PARITY if PARITY_CHECK else STOP.
- PARITY: 16th tick sample; parity error = (XOR of data bits XOR parity bit) != (EVEN_ODD_PARITY ? 0 : 1).
- STOP: each 16th tick sample; any low sample sets frame error; after M_STOP samples → IDLE, assert o_rx_done.
- On done: o_data, o_parity_error, o_frame_error update together and hold until next done. Frame with frame error still reports o_data.
- Line low in IDLE immediately after a frame (break) starts a new frame; no extra idle required.

## Timing
- Reset: state IDLE, counters 0, o_data 0, o_rx_done 0, both error flags 0.
- Reset mid-frame aborts immediately; partial frame discarded, no done.
- o_rx_done is high exactly one clock, on the clock after the tick that samples the last stop bit.
- Start-edge to done: 7 + 16·(N_DATA + PARITY_CHECK + M_STOP) ticks (plus synchronizer delay when enabled).
- o_data/error flags change only on the same edge that raises o_rx_done.

## Configuration
- UART_RX_SYNC_EN defined: i_data passes a 2-flop synchronizer (reset to 1) before sampling; adds 2 clocks latency to edge detection and done.
- Undefined: i_data sampled directly (for already-synchronous loopback benches); no added latency.

## Test plan
- Frame 0xEE, even parity bit 0, 1 stop, 16 clocks/tick spacing 1 → o_rx_done once, o_data=0xEE, both errors 0.
- Frame 0x25 sent with parity bit 0 (wrong for even) → o_data=0x25, o_parity_error=1, o_frame_error=0.
- Frame 0x24 with stop bit driven low → o_data=0x24, o_frame_error=1; next clean frame 0xEE clears it.
- Line low for 4 ticks then high (glitch) → no o_rx_done, state returns to IDLE; following 0x24 frame received correctly.
- Assert i_reset during DATA of 0xEE → outputs return to reset values, no done; subsequent 0x24 received intact.
- Back-to-back 0xEE, 0x24 from uart_tx in loopback, i_valid gated off for 10 clocks mid-frame → two done pulses, values 0xEE then 0x24.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Serial UART receiver. The line is oversampled at 16 ticks per bit period.
// The receiver finds the start bit, checks it again at mid-bit, and then
// samples each data, parity and stop bit once per bit period, near the middle
// of the bit. When the last stop bit has been sampled, the assembled word and
// the two error flags are published. o_rx_done pulses for one clock at the
// same time.
//
// Optional build macro:
//   UART_RX_SYNC_EN  defined   -> i_data passes a 2-flop synchronizer (reset
//                                 to 1) before it is sampled. This adds 2
//                                 clocks of latency.
//                    undefined -> i_data is sampled directly.
//
// Ports:
//   i_clock         system clock, all logic on the rising edge
//   i_reset         asynchronous, active-high reset
//   i_data          serial line, idle high
//   i_valid         oversampling tick, 16 per bit period
//   o_data          last received word, LSB received first, upper bits 0
//   o_rx_done       one-clock pulse when a frame completes
//   o_parity_error  parity mismatch on the last frame
//   o_frame_error   a stop bit sampled low on the last frame
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int NB_DATA         = 8,
    parameter int N_DATA          = 8,
    parameter int LOG2_N_DATA     = 4,
    parameter int PARITY_CHECK    = 1,
    parameter int EVEN_ODD_PARITY = 1,
    parameter int M_STOP          = 1,
    parameter int LOG2_M_STOP     = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_data,
    input  logic               i_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_parity_error,
    output logic               o_frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [LOG2_N_DATA-1:0] LAST_BIT  = LOG2_N_DATA'(N_DATA - 1);
    localparam logic [LOG2_M_STOP-1:0] LAST_STOP = LOG2_M_STOP'(M_STOP - 1);
    // This is the value that (data XOR parity bit) must have in a correct frame.
    localparam logic EXPECT_PAR = (EVEN_ODD_PARITY != 0) ? 1'b0 : 1'b1;

    state_t                  state_q, state_d;
    logic [3:0]              tick_q, tick_d;
    logic [LOG2_N_DATA-1:0]  bitCnt_q, bitCnt_d;
    logic [LOG2_M_STOP-1:0]  stopCnt_q, stopCnt_d;
    logic [N_DATA-1:0]       shift_q, shift_d;
    logic                    parErr_q, parErr_d;
    logic                    frmErr_q, frmErr_d;
    logic [NB_DATA-1:0]      dataOut_q, dataOut_d;
    logic                    parErrOut_q, parErrOut_d;
    logic                    frmErrOut_q, frmErrOut_d;
    logic                    done_q, done_d;
    logic                    lineBit;
    logic [NB_DATA-1:0]      wideWord;

`ifdef UART_RX_SYNC_EN
    logic sync1_q, sync2_q;

    // The flops reset to the idle level, so leaving reset never looks like a
    // start edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_data;
            sync2_q <= sync1_q;
        end
    end

    assign lineBit = sync2_q;
`else
    assign lineBit = i_data;
`endif

    // Received data bits placed at the bottom of the output word, upper bits 0.
    always_comb begin
        wideWord = '0;
        for (int i = 0; i < N_DATA; i++) begin
            wideWord[i] = shift_q[i];
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bitCnt_q    <= '0;
            stopCnt_q   <= '0;
            shift_q     <= '0;
            parErr_q    <= 1'b0;
            frmErr_q    <= 1'b0;
            dataOut_q   <= '0;
            parErrOut_q <= 1'b0;
            frmErrOut_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bitCnt_q    <= bitCnt_d;
            stopCnt_q   <= stopCnt_d;
            shift_q     <= shift_d;
            parErr_q    <= parErr_d;
            frmErr_q    <= frmErr_d;
            dataOut_q   <= dataOut_d;
            parErrOut_q <= parErrOut_d;
            frmErrOut_q <= frmErrOut_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. Nothing moves without a tick. The START state counts
    // 8 ticks to reach the middle of the start bit. Every later bit is
    // sampled 16 ticks after the previous sample, so each sample falls near
    // the middle of its bit.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bitCnt_d    = bitCnt_q;
        stopCnt_d   = stopCnt_q;
        shift_d     = shift_q;
        parErr_d    = parErr_q;
        frmErr_d    = frmErr_q;
        dataOut_d   = dataOut_q;
        parErrOut_d = parErrOut_q;
        frmErrOut_d = frmErrOut_q;
        done_d      = 1'b0;

        if (i_valid) begin
            case (state_q)
                IDLE: begin
                    if (!lineBit) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end

                START: begin
                    if (tick_q == 4'd7) begin
                        tick_d = '0;
                        // A line that is high again at mid-bit was a glitch,
                        // not a start bit.
                        if (!lineBit) begin
                            state_d  = DATA;
                            bitCnt_d = '0;
                            parErr_d = 1'b0;
                            frmErr_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end

                DATA: begin
                    if (tick_q == 4'd15) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        shift_d[N_DATA-1] = lineBit;
                        if (bitCnt_q == LAST_BIT) begin
                            bitCnt_d  = '0;
                            stopCnt_d = '0;
                            state_d   = (PARITY_CHECK != 0) ? PARITY : STOP;
                        end else begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end

                PARITY: begin
                    if (tick_q == 4'd15) begin
                        tick_d    = '0;
                        parErr_d  = ((^shift_q) ^ lineBit) != EXPECT_PAR;
                        stopCnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end

                STOP: begin
                    if (tick_q == 4'd15) begin
                        tick_d = '0;
                        if (!lineBit) begin
                            frmErr_d = 1'b1;
                        end
                        if (stopCnt_q == LAST_STOP) begin
                            // The output word, both flags and the done pulse
                            // all update on the same edge.
                            state_d     = IDLE;
                            done_d      = 1'b1;
                            dataOut_d   = wideWord;
                            parErrOut_d = (PARITY_CHECK != 0) ? parErr_q : 1'b0;
                            frmErrOut_d = frmErr_q | ~lineBit;
                        end else begin
                            stopCnt_d = stopCnt_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign o_data         = dataOut_q;
    assign o_rx_done      = done_q;
    assign o_parity_error = parErrOut_q;
    assign o_frame_error  = frmErrOut_q;

endmodule
